vga_vtim: RTL and testbench
===========================

# vga_vtim

Programmable one-dimensional video timing generator. It produces a repeating sync pulse, a delayed active-video gate, and an end-of-period strobe. Two instances are used in the VGA/LCD path: a horizontal timer clocked per pixel, and a vertical timer enabled once per line. All durations are runtime inputs, so any video mode can be produced without re-synthesis.

## Interface
- `SHORT_W`, default 8: width of `Tsync` and `Tgdel`.
- `LONG_W`, default 16: width of `Tgate` and `Tlen`, and of the internal counters.
- `clk`, input, 1: master clock; all logic is on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `ena`, input, 1: count enable. When low, all state, counters and outputs hold.
- `Tsync`, input, `SHORT_W`: sync duration minus 1, in enabled cycles.
- `Tgdel`, input, `SHORT_W`: gate delay (sync end to gate start) minus 1.
- `Tgate`, input, `LONG_W`: gate length minus 1.
- `Tlen`, input, `LONG_W`: total line/frame period minus 1.
- `Sync`, output, 1: synchronization pulse, registered.
- `Gate`, output, 1: active-video gate, registered.
- `Done`, output, 1: one-cycle strobe marking the start of a new period after a completed one, registered.

## Operation
- States: IDLE, SYNC, GDEL, GATE, LEN.
- Two counters run side by side:
  - phase counter `cnt` (`LONG_W` bits), decrements every enabled cycle.
  - period counter `cnt_len` (`LONG_W` bits), decrements every enabled cycle and saturates at 0 (never wraps).
- `cnt_done` is true when `cnt == 0`. `len_done` is true when `cnt_len == 0`.
- All transitions below happen only on edges where `ena == 1`.
- IDLE:
  - go to SYNC
  - load `cnt <= Tsync`, `cnt_len <= Tlen`
  - set `Sync <= 1`; `Done` stays 0
- SYNC: on `cnt_done`, go to GDEL, load `cnt <= Tgdel` (zero-extended), set `Sync <= 0`.
- GDEL: on `cnt_done`, go to GATE, load `cnt <= Tgate`, set `Gate <= 1`.
- GATE: on `cnt_done`, go to LEN, set `Gate <= 0`.
- LEN: on `len_done`:
  - go to SYNC
  - load `cnt <= Tsync`, `cnt_len <= Tlen`
  - set `Sync <= 1`, `Done <= 1`
- `Done` defaults to 0 on every enabled cycle in which it is not set. When `ena == 0`, `Done` holds.
- Timing inputs are sampled only at the moment they are loaded. Changes mid-phase take effect at the next load of that field.
- Resulting durations in enabled cycles:
  - Sync = `Tsync+1`
  - gate delay = `Tgdel+1`
  - Gate = `Tgate+1`
  - period = max(`Tlen+1`, `Tsync+Tgdel+Tgate+4`)
- Overrun: if `Tlen` is shorter than the phases, `cnt_len` saturates at 0. LEN is then held for exactly one cycle before the restart.
- All-zero inputs are legal: Sync 1, delay 1, Gate 1, period 4.

## Timing
- Reset (`rst_n == 0` at an edge, regardless of `ena`): state IDLE, counters 0, `Sync = Gate = Done = 0`.
- Reset mid-period aborts immediately. After release, the first enabled edge raises `Sync`, giving 1 cycle of latency from reset release.
- `Sync` and `Gate` are never high together. At least `Tgdel+1` cycles separate the `Sync` fall from the `Gate` rise.
- `Done` rises on the same edge as `Sync` for every period except the first after reset. Its width is 1 enabled cycle.
- No combinational path from inputs to outputs.

## Structure
- Shared package `vga_pkg`:
  - state enum `vtim_state_t` (IDLE, SYNC, GDEL, GATE, LEN)
  - default widths `SHORT_W = 8`, `LONG_W = 16`
- Optional sub-module `vtim_cnt`: loadable down-counter with a zero flag and a saturate option. Instantiate it twice (phase counter and period counter). Everything else stays flat in `vga_vtim`.

## Test plan
- `Tsync=4, Tgdel=5, Tgate=6, Tlen=7`, `ena=1`, reset pulsed 3 cycles:
  - `Sync` high 5 cycles, low 6, then `Gate` high 7, then 1 LEN cycle
  - period 19; `Done` pulses each restart, not the first.
- `Tsync=1, Tgdel=2, Tgate=9, Tlen=39` -> `Sync` 2 cycles, gap 3, `Gate` 10 cycles, period exactly 40, `Done` every 40 cycles.
- All inputs 0 -> `Sync`, gap and `Gate` each 1 cycle, period 4.
- `ena` toggled 1/0 alternately with the first-case values -> all output durations double in clk cycles; outputs hold on disabled cycles.
- Assert `rst_n=0` while `Gate=1` -> next edge: all outputs 0; first enabled edge after release: `Sync=1`, `Done=0`.
- Change `Tgate` from 6 to 2 during SYNC -> that period's `Gate` is 3 cycles. Change it during GATE -> takes effect the following period.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default widths for the VGA/LCD timing path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    localparam int SHORT_W = 8;
    localparam int LONG_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        GDEL,
        GATE,
        LEN
    } vtim_state_t;

endpackage

// File: rtl/vtim_cnt.sv
// Loadable down-counter with a zero flag, optionally saturating at zero instead of wrapping.
// Latency: a load or decrement on an enabled edge is visible on the flag the following cycle.
// Backpressure: none; ena low freezes the count.
module vtim_cnt #(
    parameter int W   = 16,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; otherwise count down, parking at zero when saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (ena) begin
            if (ld) begin
                cnt_d = ld_val;
            end else if (!(SAT && (cnt_q == '0))) begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/vga_vtim.sv
// One-dimensional video timer: sync pulse, delayed active gate and end-of-period strobe.
// Latency: outputs are registered; Sync rises on the first enabled edge after reset release.
// Backpressure: none; ena low freezes state, counters and outputs.
module vga_vtim #(
    parameter int SHORT_W = vga_pkg::SHORT_W,
    parameter int LONG_W  = vga_pkg::LONG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [SHORT_W-1:0] Tsync,
    input  logic [SHORT_W-1:0] Tgdel,
    input  logic [LONG_W-1:0]  Tgate,
    input  logic [LONG_W-1:0]  Tlen,
    output logic               Sync,
    output logic               Gate,
    output logic               Done
);

    import vga_pkg::*;

    vtim_state_t       state_q, state_d;
    logic              sync_q, sync_d;
    logic              gate_q, gate_d;
    logic              done_q, done_d;

    logic              cnt_ld;
    logic [LONG_W-1:0] cnt_ld_val;
    logic              cnt_done;
    logic              len_ld;
    logic              len_done;

    // Phase counter: times sync, gate delay and gate; free-runs (and may wrap) during LEN.
    vtim_cnt #(
        .W   (LONG_W),
        .SAT (1'b0)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ld     (cnt_ld),
        .ld_val (cnt_ld_val),
        .zero   (cnt_done)
    );

    // Period counter: saturates so an over-short Tlen just leaves one LEN cycle.
    vtim_cnt #(
        .W   (LONG_W),
        .SAT (1'b1)
    ) u_len (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ld     (len_ld),
        .ld_val (Tlen),
        .zero   (len_done)
    );

    // Next state, output values and counter loads; timing inputs are only sampled on a load.
    always_comb begin
        state_d    = state_q;
        sync_d     = sync_q;
        gate_d     = gate_q;
        done_d     = done_q;
        cnt_ld     = 1'b0;
        cnt_ld_val = '0;
        len_ld     = 1'b0;
        if (ena) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    state_d    = SYNC;
                    cnt_ld     = 1'b1;
                    cnt_ld_val = LONG_W'(Tsync);
                    len_ld     = 1'b1;
                    sync_d     = 1'b1;
                end
                SYNC: begin
                    if (cnt_done) begin
                        state_d    = GDEL;
                        cnt_ld     = 1'b1;
                        cnt_ld_val = LONG_W'(Tgdel);
                        sync_d     = 1'b0;
                    end
                end
                GDEL: begin
                    if (cnt_done) begin
                        state_d    = GATE;
                        cnt_ld     = 1'b1;
                        cnt_ld_val = Tgate;
                        gate_d     = 1'b1;
                    end
                end
                GATE: begin
                    if (cnt_done) begin
                        state_d = LEN;
                        gate_d  = 1'b0;
                    end
                end
                LEN: begin
                    if (len_done) begin
                        state_d    = SYNC;
                        cnt_ld     = 1'b1;
                        cnt_ld_val = LONG_W'(Tsync);
                        len_ld     = 1'b1;
                        sync_d     = 1'b1;
                        done_d     = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sync_d  = 1'b0;
                    gate_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= 1'b0;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            gate_q  <= gate_d;
            done_q  <= done_d;
        end
    end

    assign Sync = sync_q;
    assign Gate = gate_q;
    assign Done = done_q;

endmodule

// File: tb/tb_vga_vtim.sv
// Self-checking bench for vga_vtim: position-based reference model plus directed duration checks.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: n/a.
module tb_vga_vtim;

    localparam int FAR = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [7:0]  Tsync = '0;
    logic [7:0]  Tgdel = '0;
    logic [15:0] Tgate = '0;
    logic [15:0] Tlen = '0;
    logic        Sync;
    logic        Gate;
    logic        Done;

    vga_vtim dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .Tsync (Tsync),
        .Tgdel (Tgdel),
        .Tgate (Tgate),
        .Tlen  (Tlen),
        .Sync  (Sync),
        .Gate  (Gate),
        .Done  (Done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: position within the period, counted in enabled edges, and the
    // boundary positions derived from the timing values captured when each one applies.
    bit   m_run = 1'b0;
    int   m_pos = 0;
    int   m_sync_end = 0;
    int   m_gate_start = FAR;
    int   m_gate_end = FAR;
    int   m_tl = 0;
    logic e_sync = 1'b0;
    logic e_gate = 1'b0;
    logic e_done = 1'b0;

    task automatic start_period();
        m_pos        = 0;
        m_sync_end   = int'(Tsync) + 1;
        m_tl         = int'(Tlen);
        m_gate_start = FAR;
        m_gate_end   = FAR;
    endtask

    task automatic model_edge();
        int period_end;
        if (!rst_n) begin
            m_run  = 1'b0;
            e_sync = 1'b0;
            e_gate = 1'b0;
            e_done = 1'b0;
        end else if (ena) begin
            e_done = 1'b0;
            if (!m_run) begin
                m_run = 1'b1;
                start_period();
            end else begin
                m_pos++;
                period_end = (m_tl + 1 > m_gate_end + 1) ? m_tl + 1 : m_gate_end + 1;
                if (m_pos == m_sync_end) begin
                    m_gate_start = m_sync_end + int'(Tgdel) + 1;
                end else if (m_pos == m_gate_start) begin
                    m_gate_end = m_gate_start + int'(Tgate) + 1;
                end else if (m_pos > m_gate_start && m_pos == period_end) begin
                    start_period();
                    e_done = 1'b1;
                end
            end
            e_sync = (m_pos < m_sync_end);
            e_gate = (m_pos >= m_gate_start) && (m_pos < m_gate_end);
        end
    endtask

    // Measurements taken from the DUT outputs for the directed duration checks.
    int   cyc = 0;
    int   last_done = -1;
    int   done_gap = -1;
    int   gate_run = 0;
    int   gate_len = -1;
    logic done_prev = 1'b0;

    task automatic meas_clear();
        last_done = -1;
        done_gap  = -1;
        gate_run  = 0;
        gate_len  = -1;
    endtask

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        rst_n = r;
        ena   = e;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check("sync", Sync, e_sync);
        check("gate", Gate, e_gate);
        check("done", Done, e_done);
        if (Done && !done_prev) begin
            if (last_done >= 0) done_gap = cyc - last_done;
            last_done = cyc;
        end
        done_prev = Done;
        if (Gate) begin
            gate_run++;
        end else begin
            if (gate_run > 0) gate_len = gate_run;
            gate_run = 0;
        end
    endtask

    task automatic set_t(input int ts, input int tg, input int tga, input int tl);
        Tsync = 8'(ts);
        Tgdel = 8'(tg);
        Tgate = 16'(tga);
        Tlen  = 16'(tl);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        meas_clear();
    endtask

    initial begin
        // Reset state, then first enabled edge raises Sync without Done.
        set_t(4, 5, 6, 7);
        do_reset();
        check("reset_sync", Sync, 0);
        check("reset_gate", Gate, 0);
        check("reset_done", Done, 0);
        step(1'b1, 1'b1);
        check("first_sync", Sync, 1);
        check("first_done", Done, 0);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b1);
        check("case1_period", done_gap, 19);
        check("case1_gate_len", gate_len, 7);

        // Tlen longer than the phases sets the period.
        set_t(1, 2, 9, 39);
        do_reset();
        for (int i = 0; i < 130; i++) step(1'b1, 1'b1);
        check("case2_period", done_gap, 40);
        check("case2_gate_len", gate_len, 10);

        // All-zero timing values.
        set_t(0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        check("zero_period", done_gap, 4);
        check("zero_gate_len", gate_len, 1);

        // Alternating enable doubles every duration in clock cycles.
        set_t(4, 5, 6, 7);
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        check("half_ena_period", done_gap, 38);
        check("half_ena_gate_len", gate_len, 14);

        // Reset asserted while Gate is high aborts the period.
        set_t(4, 5, 6, 7);
        do_reset();
        for (int i = 0; i < 40 && !Gate; i++) step(1'b1, 1'b1);
        check("pre_rst_gate", Gate, 1);
        step(1'b0, 1'b1);
        check("midrst_sync", Sync, 0);
        check("midrst_gate", Gate, 0);
        check("midrst_done", Done, 0);
        step(1'b1, 1'b1);
        check("post_rst_sync", Sync, 1);
        check("post_rst_done", Done, 0);

        // Tgate changed during SYNC applies to the same period.
        set_t(4, 5, 6, 7);
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        Tgate = 16'd2;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
        check("tgate_in_sync", gate_len, 3);

        // Tgate changed during GATE applies only from the next period.
        Tgate = 16'd6;
        for (int i = 0; i < 60 && !Done; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 60 && !Gate; i++) step(1'b1, 1'b1);
        Tgate = 16'd2;
        gate_len = -1;
        for (int i = 0; i < 60 && Gate; i++) step(1'b1, 1'b1);
        check("tgate_in_gate_now", gate_len, 7);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
        check("tgate_in_gate_next", gate_len, 3);

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                set_t(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 12)), int'($urandom_range(0, 50)));
            end
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
